// File: rtl/bbot_rc_pkg.sv
// Shared constants and FSM encoding for the RC pulse receive/transmit paths.
package bbot_rc_pkg;

  localparam int ZERO_PULSES      = 75000;
  localparam int RANGE_MULT       = 250;
  localparam int MAX_PCT          = 100;
  localparam int MIN_WIDTH        = 45000;
  localparam int MAX_WIDTH        = 105000;
  localparam int TIMEOUT_CYCLES   = 2200000;
  localparam int RC_PERIOD_PULSES = 1100000;

  typedef enum logic [2:0] {
    ST_WAIT_LOW,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_CHECK,
    ST_CONVERT
  } rc_state_t;

endpackage

// File: rtl/bbot_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus rise/fall strobes.
module bbot_sync_edge (
  input  logic clock,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync_p0, sync_p1, sync_p2;

  // Pure data path: the chain keeps tracking the pin through reset so the
  // level seen at reset release is the true pin state.
  always_ff @(posedge clock) begin
    sync_p0 <= d;
    sync_p1 <= sync_p0;
    sync_p2 <= sync_p1;
  end

  assign level = sync_p1;
  assign rise  = sync_p1 & ~sync_p2;
  assign fall  = ~sync_p1 & sync_p2;

endmodule

// File: rtl/bbot_rc_pulse_decoder.sv
// Measures one RC servo pulse high time and converts it to a signed percent.
module bbot_rc_pulse_decoder
  import bbot_rc_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ZERO_PULSES    = bbot_rc_pkg::ZERO_PULSES,
  parameter int RANGE_MULT     = bbot_rc_pkg::RANGE_MULT,
  parameter int MAX_PCT        = bbot_rc_pkg::MAX_PCT,
  parameter int MIN_WIDTH      = bbot_rc_pkg::MIN_WIDTH,
  parameter int MAX_WIDTH      = bbot_rc_pkg::MAX_WIDTH,
  parameter int TIMEOUT_CYCLES = bbot_rc_pkg::TIMEOUT_CYCLES
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     rc_in,
  output logic        [DATA_W-1:0] pulse_width,
  output logic signed [7:0]        percent_out,
  output logic                     valid,
  output logic                     width_err,
  output logic                     signal_lost
);

  localparam logic [DATA_W-1:0] ZERO_W  = DATA_W'(ZERO_PULSES);
  localparam logic [DATA_W-1:0] RANGE_W = DATA_W'(RANGE_MULT);
  localparam logic [DATA_W-1:0] MIN_W   = DATA_W'(MIN_WIDTH);
  localparam logic [DATA_W-1:0] MAX_W   = DATA_W'(MAX_WIDTH);
  localparam logic [DATA_W-1:0] SAT_W   = DATA_W'(MAX_WIDTH + 1);
  localparam logic [DATA_W-1:0] TMO_W   = DATA_W'(TIMEOUT_CYCLES);
  localparam logic [7:0]        MAX_Q   = 8'(MAX_PCT);

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v,
                                                input logic [DATA_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

  function automatic logic signed [7:0] apply_sign(input logic [7:0] q,
                                                   input logic       neg);
    return neg ? -$signed(q) : $signed(q);
  endfunction

  logic              sync_level, sync_rise, sync_fall;
  rc_state_t         state;
  rc_state_t         exit_state;
  logic [DATA_W-1:0] width_cnt;
  logic [DATA_W-1:0] rem;
  logic [7:0]        quot;
  logic              neg;
  logic [DATA_W-1:0] tmo_cnt;
  logic [DATA_W-1:0] tmo_nxt;

  bbot_sync_edge u_sync (
    .clock (clock),
    .d     (rc_in),
    .level (sync_level),
    .rise  (sync_rise),
    .fall  (sync_fall)
  );

  // A pulse still high when CHECK/CONVERT finishes must not be measured half-way.
  assign exit_state = sync_level ? ST_WAIT_LOW : ST_WAIT_RISE;
  assign tmo_nxt    = sat_inc(tmo_cnt, TMO_W);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_WAIT_LOW;
      width_cnt   <= '0;
      rem         <= '0;
      quot        <= '0;
      neg         <= 1'b0;
      tmo_cnt     <= '0;
      pulse_width <= ZERO_W;
      percent_out <= '0;
      valid       <= 1'b0;
      width_err   <= 1'b0;
      signal_lost <= 1'b1;
    end else if (!enable) begin
      state     <= ST_WAIT_LOW;
      valid     <= 1'b0;
      width_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      width_err <= 1'b0;
      tmo_cnt   <= tmo_nxt;
      if (tmo_nxt == TMO_W) signal_lost <= 1'b1;

      case (state)
        ST_WAIT_LOW: begin
          if (!sync_level) state <= ST_WAIT_RISE;
        end
        ST_WAIT_RISE: begin
          if (sync_rise) begin
            width_cnt <= DATA_W'(1);
            state     <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (sync_fall) state <= ST_CHECK;
          else           width_cnt <= sat_inc(width_cnt, SAT_W);
        end
        ST_CHECK: begin
          if (width_cnt >= MIN_W && width_cnt <= MAX_W) begin
            neg   <= (width_cnt < ZERO_W);
            rem   <= (width_cnt < ZERO_W) ? ZERO_W - width_cnt : width_cnt - ZERO_W;
            quot  <= '0;
            state <= ST_CONVERT;
          end else begin
            width_err <= 1'b1;
            state     <= exit_state;
          end
        end
        ST_CONVERT: begin
          // Serial divide: one subtraction per cycle, truncating toward zero.
          if (quot == MAX_Q || rem < RANGE_W) begin
            pulse_width <= width_cnt;
            percent_out <= apply_sign(quot, neg);
            valid       <= 1'b1;
            tmo_cnt     <= '0;
            signal_lost <= 1'b0;
            state       <= exit_state;
          end else begin
            rem  <= rem - RANGE_W;
            quot <= quot + 8'd1;
          end
        end
        default: state <= ST_WAIT_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_bbot_rc_pulse_decoder.sv
// Directed bench for bbot_rc_pulse_decoder with scaled-down timing parameters.
module tb_bbot_rc_pulse_decoder;

  localparam int ZERO = 600;
  localparam int RNG  = 4;
  localparam int MAXP = 100;
  localparam int MINW = 120;
  localparam int MAXW = 1080;
  localparam int TMO  = 3000;
  localparam int GAP  = 150;

  logic               clock = 1'b0;
  logic               reset;
  logic               enable;
  logic               rc_in;
  logic        [31:0] pulse_width;
  logic signed [7:0]  percent_out;
  logic               valid;
  logic               width_err;
  logic               signal_lost;

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  int n_err = 0;

  bbot_rc_pulse_decoder #(
    .DATA_W(32), .ZERO_PULSES(ZERO), .RANGE_MULT(RNG), .MAX_PCT(MAXP),
    .MIN_WIDTH(MINW), .MAX_WIDTH(MAXW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .rc_in       (rc_in),
    .pulse_width (pulse_width),
    .percent_out (percent_out),
    .valid       (valid),
    .width_err   (width_err),
    .signal_lost (signal_lost)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (valid === 1'b1)     n_valid++;
    if (width_err === 1'b1) n_err++;
  end

  typedef struct {
    int width;
    int exp_valid;
    int exp_err;
    int exp_pct;
    int exp_pw;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send_pulse(input int w);
    @(negedge clock) rc_in = 1'b1;
    repeat (w) @(negedge clock);
    rc_in = 1'b0;
    repeat (GAP) @(negedge clock);
  endtask

  task automatic run_pulse(input string name, input int w, input int ev, input int ee,
                           input int epct, input int epw, input int elost);
    int v0, e0;
    v0 = n_valid;
    e0 = n_err;
    send_pulse(w);
    chk({name, " valid_count"}, n_valid - v0, ev);
    chk({name, " err_count"},   n_err - e0,   ee);
    chk({name, " percent"},     percent_out,  epct);
    chk({name, " width"},       pulse_width,  epw);
    chk({name, " lost"},        {31'd0, signal_lost}, elost);
  endtask

  initial begin
    int v0, e0;
    tbl[0]  = '{600,  1, 0,    0,  600};
    tbl[1]  = '{600,  1, 0,    0,  600};
    tbl[2]  = '{1000, 1, 0,  100, 1000};
    tbl[3]  = '{1020, 1, 0,  100, 1020};
    tbl[4]  = '{603,  1, 0,    0,  603};
    tbl[5]  = '{604,  1, 0,    1,  604};
    tbl[6]  = '{200,  1, 0, -100,  200};
    tbl[7]  = '{597,  1, 0,    0,  597};
    tbl[8]  = '{596,  1, 0,   -1,  596};
    tbl[9]  = '{100,  0, 1,   -1,  596};
    tbl[10] = '{1100, 0, 1,   -1,  596};
    tbl[11] = '{120,  1, 0, -100,  120};
    tbl[12] = '{1080, 1, 0,  100, 1080};
    tbl[13] = '{1081, 0, 1,  100, 1080};
    tbl[14] = '{700,  1, 0,   25,  700};

    reset  = 1'b1;
    enable = 1'b1;
    rc_in  = 1'b0;
    repeat (5) @(negedge clock);
    chk("rst width",   pulse_width, ZERO);
    chk("rst percent", percent_out, 0);
    chk("rst valid",   {31'd0, valid}, 0);
    chk("rst err",     {31'd0, width_err}, 0);
    chk("rst lost",    {31'd0, signal_lost}, 1);
    reset = 1'b0;
    repeat (10) @(negedge clock);

    for (int i = 0; i < 15; i++)
      run_pulse($sformatf("vec%0d", i), tbl[i].width, tbl[i].exp_valid, tbl[i].exp_err,
                tbl[i].exp_pct, tbl[i].exp_pw, 0);

    chk("neg100 raw bits", {24'd0, 8'(-100)}, 32'h9C);

    // Silence beyond the timeout window: outputs hold, signal_lost rises.
    repeat (TMO + 100) @(negedge clock);
    chk("tmo lost",    {31'd0, signal_lost}, 1);
    chk("tmo percent", percent_out, 25);
    chk("tmo width",   pulse_width, 700);
    run_pulse("after_tmo", 680, 1, 0, 20, 680, 0);

    enable = 1'b0;
    run_pulse("disabled", 800, 0, 0, 20, 680, 0);
    enable = 1'b1;
    repeat (5) @(negedge clock);
    run_pulse("reenabled", 800, 1, 0, 50, 800, 0);

    // Reset in the middle of a measurement.
    v0 = n_valid;
    e0 = n_err;
    @(negedge clock) rc_in = 1'b1;
    repeat (100) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst width",   pulse_width, ZERO);
    chk("midrst percent", percent_out, 0);
    chk("midrst lost",    {31'd0, signal_lost}, 1);
    reset = 1'b0;
    repeat (200) @(negedge clock);
    rc_in = 1'b0;
    repeat (GAP) @(negedge clock);
    chk("midrst valid_count", n_valid - v0, 0);
    chk("midrst err_count",   n_err - e0, 0);

    // Input already high at reset release: the partial pulse is ignored.
    v0 = n_valid;
    e0 = n_err;
    reset = 1'b1;
    rc_in = 1'b1;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    repeat (300) @(negedge clock);
    rc_in = 1'b0;
    repeat (GAP) @(negedge clock);
    chk("partial valid_count", n_valid - v0, 0);
    chk("partial err_count",   n_err - e0, 0);
    chk("partial width",       pulse_width, ZERO);
    run_pulse("post_partial", 640, 1, 0, 10, 640, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
